// File: rtl/calc2_top.sv
// calc2_top: four-port tagged 32-bit integer calculator.
//
// Each requester sends a command with operand 1 in one cycle and operand 2 in
// the next. A per-port capture FSM assembles the request and pushes it into a
// per-port FIFO. Each cycle, one shared add/sub unit and one shared shift unit
// each accept at most one FIFO head. Each unit arbitrates round-robin over the
// ports. Invalid commands skip both units but use the same pipeline slot. The
// result comes back on the requesting port with its tag echoed.
//
// Ports:
//   c_clk, reset         clock, asynchronous active-high reset
//   reqN_cmd_in  [3:0]   0 no-op, 1 add, 2 sub, 5 shl, 6 shr, others invalid
//   reqN_data_in [31:0]  operand 1 in the command cycle, operand 2 in the next
//   reqN_tag_in  [1:0]   tag, sampled in the command cycle
//   out_respN    [1:0]   0 idle, 1 success, 2 error
//   out_dataN    [31:0]  result (0 on error or idle)
//   out_tagN     [1:0]   tag of the completed request (0 when idle)
//   dbg_cap_state_o[3:0] bit N-1 set while port N's capture FSM is in OP2
//
// Handshake: there is no back-pressure. A command is accepted whenever the
// port FSM is in IDLE and cmd != 0. If the port FIFO is full when operand 2
// arrives, the request is dropped. A response is valid for one cycle while
// out_respN != 0.
module calc2_top #(
  parameter int QDEPTH = 4
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [1:0]  req1_tag_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [31:0] req2_data_in,
  input  logic [1:0]  req2_tag_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [31:0] req3_data_in,
  input  logic [1:0]  req3_tag_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req4_data_in,
  input  logic [1:0]  req4_tag_in,
  output logic [1:0]  out_resp1,
  output logic [31:0] out_data1,
  output logic [1:0]  out_tag1,
  output logic [1:0]  out_resp2,
  output logic [31:0] out_data2,
  output logic [1:0]  out_tag2,
  output logic [1:0]  out_resp3,
  output logic [31:0] out_data3,
  output logic [1:0]  out_tag3,
  output logic [1:0]  out_resp4,
  output logic [31:0] out_data4,
  output logic [1:0]  out_tag4,
  output logic [3:0]  dbg_cap_state_o
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic {CAP_IDLE, CAP_OP2} cap_state_e;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  tag;
    logic [31:0] op1;
    logic [31:0] op2;
  } req_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Per-port input bundles
  logic [3:0]  cmd_in  [4];
  logic [31:0] data_in [4];
  logic [1:0]  tag_in  [4];
  assign cmd_in[0] = req1_cmd_in;  assign data_in[0] = req1_data_in;  assign tag_in[0] = req1_tag_in;
  assign cmd_in[1] = req2_cmd_in;  assign data_in[1] = req2_data_in;  assign tag_in[1] = req2_tag_in;
  assign cmd_in[2] = req3_cmd_in;  assign data_in[2] = req3_data_in;  assign tag_in[2] = req3_tag_in;
  assign cmd_in[3] = req4_cmd_in;  assign data_in[3] = req4_data_in;  assign tag_in[3] = req4_tag_in;

  // ---------------- Capture FSM (three processes) ----------------
  cap_state_e  cap_state_q [4];
  cap_state_e  cap_state_d [4];
  logic [3:0]  load_op1, push;
  logic [3:0]  cap_cmd_q [4];
  logic [1:0]  cap_tag_q [4];
  logic [31:0] cap_op1_q [4];

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cap_state_q[i] <= CAP_IDLE;
    end else begin
      for (int i = 0; i < 4; i++) cap_state_q[i] <= cap_state_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cap_state_d[i] = cap_state_q[i];
      case (cap_state_q[i])
        CAP_IDLE: if (cmd_in[i] != 4'd0) cap_state_d[i] = CAP_OP2;
        CAP_OP2:  cap_state_d[i] = CAP_IDLE;
        default:  cap_state_d[i] = CAP_IDLE;
      endcase
    end
  end

  always_comb begin
    load_op1 = '0;
    push     = '0;
    for (int i = 0; i < 4; i++) begin
      load_op1[i]        = (cap_state_q[i] == CAP_IDLE) && (cmd_in[i] != 4'd0);
      push[i]            = (cap_state_q[i] == CAP_OP2);
      dbg_cap_state_o[i] = (cap_state_q[i] == CAP_OP2);
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        cap_cmd_q[i] <= '0;
        cap_tag_q[i] <= '0;
        cap_op1_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load_op1[i]) begin
          cap_cmd_q[i] <= cmd_in[i];
          cap_tag_q[i] <= tag_in[i];
          cap_op1_q[i] <= data_in[i];
        end
      end
    end
  end

  // ---------------- Per-port FIFOs ----------------
  req_t          fifo_mem_q [4][QDEPTH];
  logic [PW-1:0] wr_ptr_q [4];
  logic [PW-1:0] rd_ptr_q [4];
  logic [CW-1:0] count_q  [4];
  logic [3:0]    push_ok, pop;
  req_t          head [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      // A full FIFO drops the new request even if the head pops this cycle.
      push_ok[i] = push[i] && (count_q[i] < CW'(QDEPTH));
      head[i]    = fifo_mem_q[i][rd_ptr_q[i]];
    end
  end

  always_ff @(posedge c_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push_ok[i])
        fifo_mem_q[i][wr_ptr_q[i]] <= '{cmd: cap_cmd_q[i], tag: cap_tag_q[i],
                                        op1: cap_op1_q[i], op2: data_in[i]};
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push_ok[i]) wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
        if (pop[i])     rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
        count_q[i] <= count_q[i] + CW'(push_ok[i]) - CW'(pop[i]);
      end
    end
  end

  // ---------------- Dispatch ----------------
  logic [3:0] as_req, sh_req, inv_req;
  logic [1:0] as_ptr_q, sh_ptr_q;
  logic       as_gnt, sh_gnt;
  logic [1:0] as_idx, sh_idx;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      as_req[i]  = (count_q[i] != '0) && (head[i].cmd == 4'd1 || head[i].cmd == 4'd2);
      sh_req[i]  = (count_q[i] != '0) && (head[i].cmd == 4'd5 || head[i].cmd == 4'd6);
      inv_req[i] = (count_q[i] != '0) && !as_req[i] && !sh_req[i];
    end
  end

  // Round-robin: scan from the pointer downward in priority so the first
  // requester at or after the pointer wins.
  always_comb begin
    logic [1:0] idx;
    idx    = '0;
    as_gnt = 1'b0;
    as_idx = '0;
    sh_gnt = 1'b0;
    sh_idx = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = as_ptr_q + 2'(k);
      if (as_req[idx]) begin as_gnt = 1'b1; as_idx = idx; end
      idx = sh_ptr_q + 2'(k);
      if (sh_req[idx]) begin sh_gnt = 1'b1; sh_idx = idx; end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      pop[i] = inv_req[i] || (as_gnt && as_idx == 2'(i)) || (sh_gnt && sh_idx == 2'(i));
  end

  // ---------------- Execute stage registers ----------------
  logic        as_vld_q, as_sub_q, sh_vld_q, sh_right_q;
  logic [1:0]  as_port_q, as_tag_q, sh_port_q, sh_tag_q;
  logic [31:0] as_op1_q, as_op2_q, sh_op1_q;
  logic [4:0]  sh_amt_q;
  logic [3:0]  inv_vld_q;
  logic [1:0]  inv_tag_q [4];

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      as_ptr_q <= '0;  sh_ptr_q <= '0;
      as_vld_q <= 1'b0; as_sub_q <= 1'b0; as_port_q <= '0; as_tag_q <= '0;
      as_op1_q <= '0;  as_op2_q <= '0;
      sh_vld_q <= 1'b0; sh_right_q <= 1'b0; sh_port_q <= '0; sh_tag_q <= '0;
      sh_op1_q <= '0;  sh_amt_q <= '0;
      inv_vld_q <= '0;
      for (int i = 0; i < 4; i++) inv_tag_q[i] <= '0;
    end else begin
      as_vld_q <= as_gnt;
      if (as_gnt) begin
        as_ptr_q  <= as_idx + 2'd1;
        as_port_q <= as_idx;
        as_sub_q  <= (head[as_idx].cmd == 4'd2);
        as_tag_q  <= head[as_idx].tag;
        as_op1_q  <= head[as_idx].op1;
        as_op2_q  <= head[as_idx].op2;
      end
      sh_vld_q <= sh_gnt;
      if (sh_gnt) begin
        sh_ptr_q   <= sh_idx + 2'd1;
        sh_port_q  <= sh_idx;
        sh_right_q <= (head[sh_idx].cmd == 4'd6);
        sh_tag_q   <= head[sh_idx].tag;
        sh_op1_q   <= head[sh_idx].op1;
        sh_amt_q   <= head[sh_idx].op2[4:0];
      end
      inv_vld_q <= inv_req;
      for (int i = 0; i < 4; i++) inv_tag_q[i] <= head[i].tag;
    end
  end

  // ---------------- Arithmetic ----------------
  logic        as_carry, as_err;
  logic [31:0] as_sum, as_res, sh_res;

  always_comb begin
    {as_carry, as_sum} = {1'b0, as_op1_q} + {1'b0, as_op2_q};
    as_err = as_sub_q ? (as_op2_q > as_op1_q) : as_carry;
    as_res = as_err ? 32'd0 : (as_sub_q ? (as_op1_q - as_op2_q) : as_sum);
    sh_res = sh_right_q ? (sh_op1_q >> sh_amt_q) : (sh_op1_q << sh_amt_q);
  end

  // ---------------- Response registers ----------------
  // Each port pops at most one head per cycle, so at most one of the three
  // sources below targets any given port in the same cycle.
  logic [1:0]  resp_q [4], resp_d [4], rtag_q [4], rtag_d [4];
  logic [31:0] rdata_q [4], rdata_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      resp_d[i]  = 2'd0;
      rdata_d[i] = 32'd0;
      rtag_d[i]  = 2'd0;
      if (inv_vld_q[i]) begin
        resp_d[i] = 2'd2;
        rtag_d[i] = inv_tag_q[i];
      end
    end
    if (as_vld_q) begin
      resp_d[as_port_q]  = as_err ? 2'd2 : 2'd1;
      rdata_d[as_port_q] = as_res;
      rtag_d[as_port_q]  = as_tag_q;
    end
    if (sh_vld_q) begin
      resp_d[sh_port_q]  = 2'd1;
      rdata_d[sh_port_q] = sh_res;
      rtag_d[sh_port_q]  = sh_tag_q;
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        resp_q[i] <= '0; rdata_q[i] <= '0; rtag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        resp_q[i] <= resp_d[i]; rdata_q[i] <= rdata_d[i]; rtag_q[i] <= rtag_d[i];
      end
    end
  end

  assign out_resp1 = resp_q[0]; assign out_data1 = rdata_q[0]; assign out_tag1 = rtag_q[0];
  assign out_resp2 = resp_q[1]; assign out_data2 = rdata_q[1]; assign out_tag2 = rtag_q[1];
  assign out_resp3 = resp_q[2]; assign out_data3 = rdata_q[2]; assign out_tag3 = rtag_q[2];
  assign out_resp4 = resp_q[3]; assign out_data4 = rdata_q[3]; assign out_tag4 = rtag_q[3];

endmodule

// File: tb/tb_calc2_top.sv
module tb_calc2_top;

  // ---------------- Clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  cmd_in  [4];
  logic [31:0] data_in [4];
  logic [1:0]  tag_in  [4];
  logic [1:0]  resp    [4];
  logic [31:0] rdata   [4];
  logic [1:0]  rtag    [4];
  logic [3:0]  dbg_state;

  calc2_top #(.QDEPTH(4)) dut (
    .c_clk(clk), .reset(rst),
    .req1_cmd_in(cmd_in[0]), .req1_data_in(data_in[0]), .req1_tag_in(tag_in[0]),
    .req2_cmd_in(cmd_in[1]), .req2_data_in(data_in[1]), .req2_tag_in(tag_in[1]),
    .req3_cmd_in(cmd_in[2]), .req3_data_in(data_in[2]), .req3_tag_in(tag_in[2]),
    .req4_cmd_in(cmd_in[3]), .req4_data_in(data_in[3]), .req4_tag_in(tag_in[3]),
    .out_resp1(resp[0]), .out_data1(rdata[0]), .out_tag1(rtag[0]),
    .out_resp2(resp[1]), .out_data2(rdata[1]), .out_tag2(rtag[1]),
    .out_resp3(resp[2]), .out_data3(rdata[2]), .out_tag3(rtag[2]),
    .out_resp4(resp[3]), .out_data4(rdata[3]), .out_tag4(rtag[3]),
    .dbg_cap_state_o(dbg_state)
  );

  // ---------------- Scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [35:0] exp_q[$];   // {resp, tag, data}
  int n_seen;

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [1:0]  tag;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  // ---------------- Driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      cmd_in[i] = '0; data_in[i] = '0; tag_in[i] = '0;
    end
  endtask

  // Leaves time just after the operand-2 capture edge.
  task automatic issue(input int p, input logic [3:0] cmd, input logic [1:0] tag,
                       input logic [31:0] op1, input logic [31:0] op2);
    cmd_in[p] = cmd; tag_in[p] = tag; data_in[p] = op1;
    step();
    cmd_in[p] = '0; data_in[p] = op2;
    step();
    data_in[p] = '0;
  endtask

  function automatic logic [3:0] busy_mask();
    logic [3:0] m;
    for (int j = 0; j < 4; j++) m[j] = (resp[j] != 2'd0);
    return m;
  endfunction

  task automatic mon_step();
    logic [35:0] e;
    step();
    if (resp[1] != 2'd0) begin
      n_seen++;
      if (exp_q.size() == 0) begin
        check("b2b_unexpected", {30'd0, resp[1], rtag[1]}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("b2b_resp", {60'd0, resp[1], rtag[1]}, {60'd0, e[35:32], e[33:32] & 2'b11} & 64'h0 | {60'd0, e[35:32]});
        check("b2b_data", {32'd0, rdata[1]}, {32'd0, e[31:0]});
      end
    end
  endtask

  // ---------------- Stimulus ----------------
  initial begin
    logic [3:0]  b_cmd [5];
    logic [31:0] b_op1 [5];
    logic [31:0] b_op2 [5];
    logic [1:0]  b_tag [5];
    logic [1:0]  b_resp [5];
    logic [31:0] b_res [5];
    int wait_cycles;

    vecs[0]  = '{0, 4'd1, 2'd1, 32'h30,       32'h20,       2'd1, 32'h50};
    vecs[1]  = '{0, 4'd1, 2'd2, 32'hFFFFFFFF, 32'h1,        2'd2, 32'h0};
    vecs[2]  = '{1, 4'd2, 2'd3, 32'h10,       32'h20,       2'd2, 32'h0};
    vecs[3]  = '{2, 4'd3, 2'd0, 32'h1234,     32'h5678,     2'd2, 32'h0};
    vecs[4]  = '{3, 4'd2, 2'd1, 32'h20,       32'h20,       2'd1, 32'h0};
    vecs[5]  = '{0, 4'd5, 2'd2, 32'h1,        32'h21,       2'd1, 32'h2};
    vecs[6]  = '{1, 4'd6, 2'd3, 32'h80000000, 32'd31,       2'd1, 32'h1};
    vecs[7]  = '{2, 4'd2, 2'd1, 32'h100,      32'h1,        2'd1, 32'hFF};
    vecs[8]  = '{3, 4'd1, 2'd2, 32'h7FFFFFFF, 32'h80000000, 2'd1, 32'hFFFFFFFF};
    vecs[9]  = '{1, 4'd15, 2'd2, 32'hABCD,    32'h1,        2'd2, 32'h0};
    vecs[10] = '{3, 4'd5, 2'd3, 32'hF0000001, 32'd4,        2'd1, 32'h10};
    vecs[11] = '{0, 4'd6, 2'd0, 32'h1234,     32'h40,       2'd1, 32'h1234};
    vecs[12] = '{2, 4'd4, 2'd3, 32'h1,        32'h1,        2'd2, 32'h0};
    vecs[13] = '{3, 4'd7, 2'd1, 32'h5,        32'h5,        2'd2, 32'h0};

    clear_inputs();
    rst = 1'b1;
    step(); step();
    for (int j = 0; j < 4; j++) begin
      check($sformatf("reset_resp%0d", j + 1), {62'd0, resp[j]}, 64'd0);
      check($sformatf("reset_data%0d", j + 1), {32'd0, rdata[j]}, 64'd0);
    end
    check("reset_fsm_state", {60'd0, dbg_state}, 64'd0);
    rst = 1'b0;
    step();

    // ---- Table-driven single requests ----
    for (int v = 0; v < NVEC; v++) begin
      issue(vecs[v].port, vecs[v].cmd, vecs[v].tag, vecs[v].op1, vecs[v].op2);
      step();
      check($sformatf("v%0d_early", v), {62'd0, resp[vecs[v].port]}, 64'd0);
      step();
      check($sformatf("v%0d_resp", v), {62'd0, resp[vecs[v].port]}, {62'd0, vecs[v].exp_resp});
      check($sformatf("v%0d_data", v), {32'd0, rdata[vecs[v].port]}, {32'd0, vecs[v].exp_data});
      check($sformatf("v%0d_tag", v), {62'd0, rtag[vecs[v].port]}, {62'd0, vecs[v].tag});
      check($sformatf("v%0d_others", v), {60'd0, busy_mask()},
            {60'd0, 4'(1 << vecs[v].port)});
      step();
      check($sformatf("v%0d_one_cycle", v), {62'd0, resp[vecs[v].port]}, 64'd0);
    end

    // ---- Reset mid-operation: port 1 in OP2 while port 2 responds ----
    issue(1, 4'd1, 2'd2, 32'd5, 32'd6);
    step();
    cmd_in[0] = 4'd1; tag_in[0] = 2'd3; data_in[0] = 32'h77;
    step();
    check("rst_pre_resp2", {62'd0, resp[1]}, 64'd1);
    check("rst_pre_data2", {32'd0, rdata[1]}, 64'd11);
    check("rst_pre_port1_op2", {60'd0, dbg_state}, 64'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_resp2", {62'd0, resp[1]}, 64'd0);
    check("rst_async_data2", {32'd0, rdata[1]}, 64'd0);
    check("rst_async_tag2", {62'd0, rtag[1]}, 64'd0);
    check("rst_async_fsm", {60'd0, dbg_state}, 64'd0);
    clear_inputs();
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("rst_idle_c%0d", c), {60'd0, busy_mask()}, 64'd0);
    end

    // ---- Contention: all four ports add in the same cycle (pointer at port 1) ----
    for (int i = 0; i < 4; i++) begin
      cmd_in[i] = 4'd1; tag_in[i] = 2'(i); data_in[i] = 32'h1000 * (i + 1);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      cmd_in[i] = '0; data_in[i] = 32'(i + 1);
    end
    step();
    clear_inputs();
    step();
    check("cont_early", {60'd0, busy_mask()}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("cont_c%0d_mask", k), {60'd0, busy_mask()}, {60'd0, 4'(1 << k)});
      check($sformatf("cont_c%0d_resp", k), {62'd0, resp[k]}, 64'd1);
      check($sformatf("cont_c%0d_data", k), {32'd0, rdata[k]}, {32'd0, 32'h1000 * (k + 1) + 32'(k + 1)});
      check($sformatf("cont_c%0d_tag", k), {62'd0, rtag[k]}, {62'd0, 2'(k)});
    end
    step();
    check("cont_done", {60'd0, busy_mask()}, 64'd0);

    // ---- Back-to-back on port 2, tags 0,1,2,3,0 ----
    b_cmd  = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1};
    b_tag  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    b_op1  = '{32'd10, 32'd100, 32'd3, 32'hF0, 32'hFFFFFFFF};
    b_op2  = '{32'd20, 32'd1, 32'd4, 32'd4, 32'd2};
    b_resp = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    b_res  = '{32'd30, 32'd99, 32'h30, 32'hF, 32'd0};
    n_seen = 0;
    for (int r = 0; r < 5; r++) begin
      exp_q.push_back({b_resp[r], b_tag[r], b_res[r]});
      cmd_in[1] = b_cmd[r]; tag_in[1] = b_tag[r]; data_in[1] = b_op1[r];
      mon_step();
      // A nonzero command during the operand-2 cycle must be ignored.
      cmd_in[1] = 4'hF; data_in[1] = b_op2[r];
      mon_step();
    end
    clear_inputs();
    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 20) begin
      mon_step();
      wait_cycles++;
    end
    for (int c = 0; c < 3; c++) mon_step();
    check("b2b_queue_drained", 64'(exp_q.size()), 64'd0);
    check("b2b_count", 64'(n_seen), 64'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/calc2_top.md
Name: calc2_top

Overview:
- Four-port, tagged 32-bit integer calculator.
- Each requester port supplies a command and operand 1 in one cycle, then operand 2 in the next cycle.
- Operations are executed by a shared add/sub unit and a shared shift unit; the result returns on the same port's response bus with the request tag echoed.
- Top level of the calculator; sits between four independent requester agents and the arithmetic datapath.

Parameters:
- QDEPTH, 4, per-port pending-request FIFO depth (one slot per tag value).

Ports:
- c_clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- reqN_cmd_in  in  4  N=1..4; command: 0 no-op, 1 add, 2 sub, 5 shift-left, 6 shift-right.
- reqN_data_in  in  32  N=1..4; operand 1 in the command cycle, operand 2 in the following cycle.
- reqN_tag_in  in  2  N=1..4; request tag, sampled in the command cycle.
- out_respN  out  2  N=1..4; 0 idle, 1 success, 2 error (overflow, underflow or invalid command), 3 never driven.
- out_dataN  out  32  N=1..4; result, valid while out_respN != 0.
- out_tagN  out  2  N=1..4; tag of the completed request.

Behaviour:
- Clock and reset: one clock, c_clk. reset is asynchronous and active-high.
- While reset is high:
  - all outputs are 0;
  - port capture state machines return to IDLE;
  - FIFOs and pipelines are emptied; any in-flight request is discarded and produces no response.
- Port capture, one state machine per port:
  - IDLE: a rising edge with cmd != 0 captures cmd, tag and data_in as operand 1, then goes to OP2.
  - OP2: the next rising edge captures data_in as operand 2, regardless of cmd, and pushes {cmd, tag, op1, op2} into the port FIFO. Back to IDLE.
  - cmd is ignored while in OP2. Holding cmd nonzero after OP2 starts a new request.
  - If the FIFO is full (4 pending), the new request is dropped silently.
- Dispatch:
  - Each cycle the add/sub unit takes at most one request (cmd 1, 2) and the shift unit takes at most one (cmd 5, 6).
  - Each unit arbitrates round-robin over ports whose FIFO head targets it. The pointer starts at port 1 after reset and advances past the granted port.
  - Only a FIFO head is eligible, so responses are in order per port.
  - Invalid commands (3, 4, 7..15) bypass both units and take the same pipeline slot, in order.
- Latency:
  - Uncontended, out_respN is nonzero for exactly one cycle: the cycle after the 2nd rising edge following the operand-2 capture edge.
  - Contention adds whole cycles.
  - At most one response per port per cycle. Responses on different ports may coincide.
- Arithmetic, all unsigned 32-bit:
  - add: op1+op2. A carry out of bit 31 gives resp 2, data 0.
  - sub: op1-op2. op2 > op1 gives resp 2, data 0. op1 == op2 gives resp 1, data 0.
  - shl: op1 << op2[4:0], zero fill. shr: op1 >> op2[4:0], logical. op2[31:5] are ignored. Always resp 1.
  - Invalid command: resp 2, data 0.
- Outputs return to resp 0, data 0, tag 0 in every cycle with no completion.
- Tag reuse while a request with the same tag is pending is allowed. Tags are only echoed, never checked.

Test Plan:
- Reset: assert reset mid-operation (port 1 in OP2) → all outputs 0 immediately. Release reset, idle 10 cycles → no response on any port.
- Port 1 add: cmd 1, tag 1, data 0x30 then 0x20 → out_resp1=1, out_data1=0x50, out_tag1=1, single cycle, 2 cycles after the operand-2 edge.
- Errors:
  - add 0xFFFFFFFF + 1 → resp 2, data 0.
  - sub 0x10 - 0x20 → resp 2, data 0.
  - cmd 3 → resp 2, data 0.
  - sub 0x20 - 0x20 → resp 1, data 0.
- Shifts: shl 0x1 by 0x21 → data 0x2 (only op2[4:0] used). shr 0x80000000 by 31 → data 0x1. Both resp 1.
- Contention: all four ports issue add in the same cycle with distinct operands → all four correct results on their own ports, one per cycle, in round-robin order 1, 2, 3, 4.
- Back-to-back: port 2 issues 5 requests, tags 0,1,2,3,0, with no gaps → five in-order responses with matching tags and results.
